// File: rtl/numpad_scan_ctrl.sv
// 4x4 numpad scanner: one-hot column drive, synchronised row sampling,
// whole-matrix debounce with ghost rejection, and a small key-event FIFO.
module numpad_scan_ctrl #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] columns,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_held,
    output logic [3:0] held_code,
    output logic       overflow
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE_SCANS);
    localparam logic [PW:0]   FIFO_FULL   = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_GHOST} res_kind_e;
    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } scan_res_t;

    // ---------------- scan sequencer ----------------
    logic [3:0]    rows_meta, rows_sync;
    logic [1:0]    col;
    logic [SW-1:0] settle;
    logic [15:0]   acc;
    logic          scan_done;

    assign columns = 4'b0001 << col;

    always_ff @(posedge clock) begin
        if (reset) begin
            rows_meta <= '0;
            rows_sync <= '0;
            col       <= '0;
            settle    <= '0;
            acc       <= '0;
            scan_done <= 1'b0;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
            scan_done <= 1'b0;
            if (settle == SETTLE_LAST) begin
                // each column slot is overwritten every scan, so no explicit clear
                acc[{col, 2'b00} +: 4] <= rows_sync;
                settle    <= '0;
                col       <= col + 2'd1;
                scan_done <= (col == 2'd3);
            end else begin
                settle <= settle + 1'b1;
            end
        end
    end

    // ---------------- scan classification ----------------
    logic [4:0] n_ones;
    logic [3:0] hit_code;
    scan_res_t  res;

    always_comb begin
        n_ones   = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (acc[i]) begin
                n_ones   = n_ones + 5'd1;
                hit_code = 4'(i);
            end
        end
        res.kind = RES_NONE;
        res.code = 4'd0;
        if (n_ones == 5'd1) begin
            res.kind = RES_KEY;
            res.code = hit_code;
        end else if (n_ones > 5'd1) begin
            res.kind = RES_GHOST;
        end
    end

    // ---------------- debounce ----------------
    scan_res_t     cand, cand_n, stable, stable_n;
    logic [DW-1:0] deb_cnt, cnt_n;
    logic          push;

    always_comb begin
        cand_n   = cand;
        cnt_n    = deb_cnt;
        stable_n = stable;
        push     = 1'b0;
        // ghost scans are invisible to the debouncer
        if (scan_done && res.kind != RES_GHOST) begin
            if (res == cand) begin
                if (deb_cnt != DEB_MAX)
                    cnt_n = deb_cnt + 1'b1;
            end else begin
                cand_n = res;
                cnt_n  = DW'(1);
            end
            if (cnt_n == DEB_MAX && cand_n != stable) begin
                stable_n = cand_n;
                push     = (cand_n.kind == RES_KEY);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cand    <= '{kind: RES_NONE, code: 4'd0};
            stable  <= '{kind: RES_NONE, code: 4'd0};
            deb_cnt <= '0;
        end else begin
            cand    <= cand_n;
            stable  <= stable_n;
            deb_cnt <= cnt_n;
        end
    end

    assign key_held  = (stable.kind == RES_KEY);
    assign held_code = stable.code;

    // ---------------- event FIFO ----------------
    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_n;
    logic [PW:0]   fcount, fcount_n, left;
    logic          full, pop, do_push, drop;
    logic          head_valid_n;
    logic [3:0]    head_code_n;

    assign full    = (fcount == FIFO_FULL);
    assign pop     = key_valid & key_ready;
    assign do_push = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // head is precomputed so key_valid/key_code come straight from flops
    always_comb begin
        fcount_n     = fcount + (PW+1)'(do_push) - (PW+1)'(pop);
        left         = fcount - (PW+1)'(pop);
        rd_n         = rd_ptr + PW'(pop);
        head_valid_n = (fcount_n != '0);
        head_code_n  = 4'd0;
        if (head_valid_n)
            head_code_n = (left == '0) ? stable_n.code : mem[rd_n];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcount    <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            overflow  <= 1'b0;
        end else begin
            fcount    <= fcount_n;
            rd_ptr    <= rd_n;
            key_valid <= head_valid_n;
            key_code  <= head_code_n;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= stable_n.code;
    end

endmodule

// File: tb/tb_numpad_scan_ctrl.sv
// Bench for numpad_scan_ctrl: directed plan scenarios plus random key patterns,
// checked against a scan-level model of debounce and event queueing.
module tb_numpad_scan_ctrl;
    localparam int SC = 4;
    localparam int DS = 2;
    localparam int FD = 4;
    localparam int NONE  = 16;
    localparam int GHOST = 17;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows, columns, key_code, held_code;
    logic       key_valid, key_held, overflow;
    logic       key_ready = 1'b1;
    logic [15:0] pressed = '0;

    int n_cmp = 0;
    int n_err = 0;

    int got_q[$];
    int exp_q[$];
    int hist[$];
    int m_stable = NONE;
    int m_occ = 0;
    bit m_ovf = 1'b0;

    numpad_scan_ctrl #(.SETTLE_CYCLES(SC), .DEBOUNCE_SCANS(DS), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .rows(rows), .columns(columns),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .key_held(key_held), .held_code(held_code), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // matrix model: a pressed key connects its column line to its row line
    always_comb begin
        rows = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (columns[c] && pressed[c*4+r]) rows[r] = 1'b1;
    end

    always @(negedge clock)
        if (!reset && key_valid && key_ready) got_q.push_back(int'(key_code));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int classify(input logic [15:0] p);
        if ($countones(p) == 0) return NONE;
        if ($countones(p) > 1) return GHOST;
        for (int i = 0; i < 16; i++) if (p[i]) return i;
        return NONE;
    endfunction

    // stable becomes r once the last DS non-ghost scans all read r
    task automatic model_scan(input logic [15:0] p);
        int r;
        bit same;
        r = classify(p);
        if (r == GHOST) return;
        hist.push_back(r);
        if (hist.size() > DS) void'(hist.pop_front());
        if (hist.size() != DS) return;
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != r) same = 1'b0;
        if (same && r != m_stable) begin
            m_stable = r;
            if (r < 16) begin
                if (key_ready) exp_q.push_back(r);
                else if (m_occ < FD) begin exp_q.push_back(r); m_occ++; end
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic wait_col0();
        logic [3:0] prev;
        bit found;
        prev = columns;
        found = 1'b0;
        for (int i = 0; i < 8*SC; i++) begin
            @(posedge clock); #1;
            if (columns == 4'b0001 && prev != 4'b0001) begin found = 1'b1; break; end
            prev = columns;
        end
        chk("scan_wrap_seen", found, 1'b1);
    endtask

    task automatic events_chk();
        int g, e;
        chk("event_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk("event_code", g, e);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // one whole scan with pattern p; called just after a column-0 wrap
    task automatic scan(input logic [15:0] p);
        pressed = p;
        wait_col0();
        if (key_ready) events_chk();
        model_scan(p);
        @(posedge clock); #1;
        chk("key_held", key_held, m_stable < 16);
        chk("held_code", held_code, (m_stable < 16) ? m_stable : 0);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic scans(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) scan(p);
    endtask

    task automatic sync_scan();
        wait_col0();
        @(posedge clock); #1;
    endtask

    task automatic model_reset();
        m_stable = NONE;
        hist.delete();
        m_occ = 0;
        m_ovf = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] p;
        int a, b, n;
        bit found;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_columns", columns, 4'b0001);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 4'd0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_held_code", held_code, 4'd0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b0;
        sync_scan();

        // single key held: one event, no repeat; re-press gives another
        scans(16'h0020, 10);
        scans(16'h0000, 3);
        scans(16'h0020, 3);
        scans(16'h0000, 3);

        // bounce on code 10, then a real hold
        for (int i = 0; i < 6; i++) begin
            scan(16'h0400);
            scan(16'h0000);
        end
        scans(16'h0400, 3);
        scans(16'h0000, 3);

        // ghost: A held, 0 added, 0 released, A released
        scans(16'h1000, 3);
        scans(16'h1008, 5);
        scans(16'h1000, 2);
        scans(16'h0000, 3);

        // direct change 0 -> 4
        scans(16'h0001, 3);
        scans(16'h0010, 3);
        scans(16'h0000, 3);

        // overflow with consumer stalled
        key_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            p = 16'h0001 << k;
            scans(p, 2);
            scans(16'h0000, 2);
        end
        chk("stall_valid", key_valid, 1'b1);
        chk("stall_head", key_code, exp_q[0]);
        @(posedge clock); #1;
        chk("stall_head_hold", key_code, exp_q[0]);
        chk("stall_overflow", overflow, 1'b1);
        key_ready = 1'b1;
        m_occ = 0;
        scans(16'h0000, 2);
        chk("drained_valid", key_valid, 1'b0);
        chk("drained_overflow", overflow, 1'b1);

        // reset in column 2 with two events queued and a key held
        key_ready = 1'b0;
        scans(16'h0080, 2);
        scans(16'h0000, 2);
        scans(16'h0200, 3);
        chk("pre_rst_valid", key_valid, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 8*SC; i++) begin
            @(posedge clock); #1;
            if (columns == 4'b0100) begin found = 1'b1; break; end
        end
        chk("col2_seen", found, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_columns", columns, 4'b0001);
        chk("mid_rst_valid", key_valid, 1'b0);
        chk("mid_rst_overflow", overflow, 1'b0);
        chk("mid_rst_held", key_held, 1'b0);
        reset = 1'b0;
        pressed = '0;
        key_ready = 1'b1;
        model_reset();
        repeat (SC-1) @(posedge clock);
        #1;
        chk("restart_col0", columns, 4'b0001);
        @(posedge clock); #1;
        chk("restart_col1", columns, 4'b0010);
        sync_scan();

        // random patterns: idle, single keys, multi-key ghosts
        for (int it = 0; it < 40; it++) begin
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            case ($urandom_range(0, 3))
                0:       p = 16'h0000;
                1, 2:    p = 16'h0001 << a;
                default: p = (16'h0001 << a) | (16'h0001 << b);
            endcase
            n = $urandom_range(1, 3);
            scans(p, n);
        end
        scans(16'h0000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/numpad_scan_ctrl.md
Name: numpad_scan_ctrl

Overview:
Scan sequencer and event queue for the 4x4 calculator numpad. Drives one-hot columns with a programmable settle time and samples the rows through a synchroniser. Debounces whole-matrix scan results and rejects multi-key (ghost) scans. Pushes one key-press event per debounced press into a small FIFO, read by the calculator core over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1000, clocks each column is driven before rows are sampled (20 us at 50 MHz); legal range >= 4.
DEBOUNCE_SCANS, 4, consecutive identical full-matrix scans required to accept a new stable state; legal range >= 1.
FIFO_DEPTH, 4, event queue entries; power of 2, >= 2.

Ports:
clock  in  1  50 MHz system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
rows  in  4  numpad rows, active-high, asynchronous to clock
columns  out  4  one-hot column drive; bit c high drives column c
key_valid  out  1  FIFO head holds an event
key_code  out  4  event code at the FIFO head; col*4 + row
key_ready  in  1  consumer accepts the head when key_valid is high
key_held  out  1  debounced stable state is a single key
held_code  out  4  code of that key; 0 when key_held=0
overflow  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Reset values: columns=4'b0001, key_valid=0, key_code=0, key_held=0, held_code=0, overflow=0. Internally col=0, settle counter=0, scan accumulator clear, candidate=NONE, debounce count=0, stable=NONE, FIFO empty. Reset asserted mid-scan or mid-handshake aborts everything and restores this state on the next edge.
- Row synchroniser: 2 flops on rows. The settle window absorbs their latency.
- Scan sequencing: the settle counter runs 0..SETTLE_CYCLES-1 while columns=1<<col. On the cycle the counter is SETTLE_CYCLES-1:
  - sample the synchronised rows for column col;
  - set col to (col+1) mod 4 and reset the counter, so columns change on the next edge.
- Column period is SETTLE_CYCLES clocks. Full scan period is 4*SETTLE_CYCLES clocks, with no idle gaps.
- Scan result after column 3 is sampled:
  - NONE if no row bit was set in any column;
  - KEY(code) if exactly one bit was set across all 4 columns, with code=col*4+row (1=0, 4=1, 7=2, 0=3, 2=4, 5=5, 8=6, F=7, 3=8, 6=9, 9=10, E=11, A=12, B=13, C=14, D=15);
  - GHOST if two or more bits were set.
- Debounce runs the cycle after the column-3 sample:
  - GHOST leaves the candidate, count and stable state unchanged.
  - A result equal to the candidate increments count, saturating at DEBOUNCE_SCANS.
  - Any other result loads the candidate and sets count=1.
  - When count reaches DEBOUNCE_SCANS and the candidate differs from stable, stable takes the candidate. If the new stable is KEY, an event is pushed on that same cycle.
- Resulting event rules:
  - A key held indefinitely yields exactly one event; there is no auto-repeat.
  - Release (stable goes to NONE) yields no event.
  - A direct change KEY(a) to KEY(b) yields an event for b.
- key_held and held_code reflect stable, updated on the same edge as stable.
- FIFO:
  - Registered outputs. A push into an empty FIFO raises key_valid on the next edge (no fall-through).
  - Pop occurs when key_valid and key_ready are both high.
  - The head is stable while key_valid=1 and key_ready=0.
  - Order is strictly FIFO.
  - A push while full with no pop that cycle drops the new event and sets overflow=1. overflow clears only on reset.
  - A push while full with a simultaneous pop accepts the push; count stays FIFO_DEPTH.
  - A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Press latency: the event appears at most (DEBOUNCE_SCANS+1)*4*SETTLE_CYCLES + 4 clocks after rows become stable.

Test Plan:
1. Bench setup: SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, key_ready=1; the bench models the matrix by setting rows from columns. Hold key 5 (column 1, row 1) for 10 scans -> exactly one event key_code=5; key_held=1 and held_code=5 throughout; no further events. Release, then press 5 again -> second event code 5.
2. Bounce: toggle key 9 (code 10) so it is present for only 1 consecutive scan, repeated 6 times -> no event, key_held stays 0. Then hold 3 scans -> one event code 10.
3. Ghost: stable key A (code 12) held, then add key 0 (code 3) for 5 scans -> no event, stable stays 12. Release 0 -> no event. Release A -> key_held=0.
4. Direct change: hold 1 (code 0) until its event, then switch to 2 (code 4) with no gap -> events 0 then 4, held_code ends at 4.
5. Overflow: key_ready=0, press and release codes 1, 2, 3, 4, 5 -> FIFO holds 4 entries, overflow=1. Set key_ready=1 -> pops 1, 2, 3, 4 in order, then key_valid=0; overflow stays 1.
6. Reset mid-operation: assert reset during column 2 with 2 events queued -> next edge columns=0001, key_valid=0, overflow=0, key_held=0. Scanning restarts from column 0.
